seg_scan_reader: RTL
====================

SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter SETTLE, default 16: consecutive identical-input cycles required before a digit is sampled; legal range 2..255.
REQ-002 Parameter TIMEOUT, default 1024: cycles without any sample before `display_dead` asserts; legal range 2..2^24.
REQ-003 `clk`  input  1  the single clock; all state changes on its rising edge.
REQ-004 `reset`  input  1  asynchronous, active-high reset.
REQ-005 `seg`  input  7  active-low segment lines, bit 0 = a through bit 6 = g, as driven by the stopwatch display driver.
REQ-006 `an`  input  4  active-low digit enables, bit 0 = rightmost digit.
REQ-007 `digits`  output  16  last complete frame as BCD nibbles, [3:0] = digit 0; nibble F = blank, E = undecodable.
REQ-008 `frame_valid`  output  1  one-cycle pulse when `digits` is updated.
REQ-009 `seg_err`  output  1  one-cycle pulse when a sampled pattern is undecodable.
REQ-010 `an_err`  output  1  one-cycle pulse when a sample point has more than one anode active.
REQ-011 `display_dead`  output  1  level; high while no sample has occurred for TIMEOUT cycles.

Function
REQ-012 The block SHALL register the previous `an` and `seg` values and keep a saturating stability counter.
- Counter clears to 0 on any cycle where {an, seg} differs from the registered previous value.
- Otherwise the counter increments, saturating at SETTLE.
REQ-013 A sample point SHALL occur exactly once per stable period: on the cycle the counter transitions from SETTLE-1 to SETTLE.
REQ-014 At a sample point with `an` == 4'b1111, the block SHALL take no action (no sample, no error).
REQ-015 At a sample point with exactly one `an` bit low, the block SHALL decode `seg` and store the nibble in that digit's capture slot, and set that digit's seen bit.
REQ-016 At a sample point with two or more `an` bits low, the block SHALL pulse `an_err` for one cycle and store nothing.
REQ-017 Decode, with `seg` written as g..a: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 1111111=F (blank).
- Any other pattern SHALL store E and pulse `seg_err` in the cycle following the sample edge.
REQ-018 Re-sampling a digit whose seen bit is already set SHALL overwrite its slot; the seen bit stays set.
REQ-019 On the sample edge that makes all four seen bits 1, the block SHALL:
- load `digits` from all four slots, including the nibble being sampled on that edge;
- assert `frame_valid` for exactly one cycle;
- clear all seen bits.
REQ-020 `digits` SHALL hold its value between frames.
REQ-021 The idle counter SHALL clear on every accepted sample (REQ-015) and otherwise increment, saturating at TIMEOUT.
- `display_dead` = (idle counter == TIMEOUT).
- `display_dead` deasserts in the cycle after the next accepted sample.
REQ-022 Samples rejected under REQ-014 or REQ-016 SHALL NOT clear the idle counter.
REQ-023 `seg_err` and `frame_valid` MAY assert in the same cycle; all outputs SHALL be registered.

Reset
REQ-024 While `reset` is high, asynchronously:
- `digits` = 16'hFFFF;
- `frame_valid`, `seg_err`, `an_err`, `display_dead` = 0;
- seen bits, capture slots, stability and idle counters = 0;
- the previous-value registers = all ones.
REQ-025 A reset asserted mid-frame SHALL discard partial captures; the first frame after reset requires four fresh samples.

Verification
REQ-026 Scan digits 0..3 showing 4,3,2,1 (digit 3 = 4), each held 20 cycles with SETTLE=16 -> exactly one `frame_valid` pulse, `digits` = 16'h4321, no errors.
REQ-027 Hold each digit exactly 15 identical cycles -> no sample, no `frame_valid`; with TIMEOUT=64, `display_dead` rises 64 cycles after reset release.
REQ-028 Drive seg=7'b1010101 on digit 2 within an otherwise valid frame of 9s -> one `seg_err` pulse and `digits` = 16'h9E99.
REQ-029 Drive an=4'b0011 held 20 cycles -> one `an_err` pulse, seen bits unchanged, no frame.
REQ-030 Sample digits 0, 1, 0 (new value 7), 2, 3 -> one frame, with digit 0 = 7 (overwrite).
REQ-031 Assert `reset` after two digits are sampled, then scan a full frame of 5s -> single frame, `digits` = 16'h5555.

Source files
------------

// File: rtl/seg_scan_reader_if.sv
// Bundle of the scanned-display lines and the reader's decoded results.
// master = the side driving the display lines, slave = seg_scan_reader.
interface seg_scan_reader_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        frame_valid;
  logic        seg_err;
  logic        an_err;
  logic        display_dead;

  modport master (
    output seg, an,
    input  digits, frame_valid, seg_err, an_err, display_dead
  );

  modport slave (
    input  seg, an,
    output digits, frame_valid, seg_err, an_err, display_dead
  );
endinterface

// File: rtl/seg_scan_reader.sv
// Snoops a multiplexed 4-digit 7-segment display, samples each digit once it has
// settled, and publishes complete BCD frames plus error and liveness indications.
module seg_scan_reader #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err,
  output logic        display_dead
);

  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    SETTLE_C  = 8'(SETTLE);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

  logic [10:0]   prev_q, prev_d;
  logic [7:0]    stab_q, stab_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   slots_q, slots_d;
  logic [15:0]   digits_q, digits_d;
  logic          frame_valid_q, frame_valid_d;
  logic          seg_err_q, seg_err_d;
  logic          an_err_q, an_err_d;
  logic          dead_q, dead_d;

  logic          sample;
  logic          accept;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          nib_bad;

  always_comb begin
    nib     = 4'hE;
    nib_bad = 1'b0;
    case (seg)
      7'b1000000: nib = 4'd0;
      7'b1111001: nib = 4'd1;
      7'b0100100: nib = 4'd2;
      7'b0110000: nib = 4'd3;
      7'b0011001: nib = 4'd4;
      7'b0010010: nib = 4'd5;
      7'b0000010: nib = 4'd6;
      7'b1111000: nib = 4'd7;
      7'b0000000: nib = 4'd8;
      7'b0010000: nib = 4'd9;
      7'b1111111: nib = 4'hF;
      default:    nib_bad = 1'b1;
    endcase
  end

  always_comb begin
    prev_d        = {an, seg};
    stab_d        = stab_q;
    sample        = 1'b0;
    seen_d        = seen_q;
    slots_d       = slots_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    an_err_d      = 1'b0;
    accept        = 1'b0;
    idx           = 2'd0;
    idle_d        = (idle_q == TIMEOUT_C) ? idle_q : idle_q + IW'(1);

    // Sample fires only on the SETTLE-1 -> SETTLE step, so once per stable period.
    if ({an, seg} != prev_q) begin
      stab_d = '0;
    end else if (stab_q != SETTLE_C) begin
      stab_d = stab_q + 8'd1;
      sample = (stab_q == SETTLE_C - 8'd1);
    end

    if (sample) begin
      case (an)
        4'b1111: ;
        4'b1110: begin accept = 1'b1; idx = 2'd0; end
        4'b1101: begin accept = 1'b1; idx = 2'd1; end
        4'b1011: begin accept = 1'b1; idx = 2'd2; end
        4'b0111: begin accept = 1'b1; idx = 2'd3; end
        default: an_err_d = 1'b1;
      endcase
    end

    if (accept) begin
      slots_d[{idx, 2'b00} +: 4] = nib;
      seen_d[idx]                = 1'b1;
      seg_err_d                  = nib_bad;
      idle_d                     = '0;
      if (&seen_d) begin
        digits_d      = slots_d;
        frame_valid_d = 1'b1;
        seen_d        = '0;
      end
    end

    dead_d = (idle_d == TIMEOUT_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q        <= '1;
      stab_q        <= '0;
      idle_q        <= '0;
      seen_q        <= '0;
      slots_q       <= '0;
      digits_q      <= '1;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      an_err_q      <= 1'b0;
      dead_q        <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      idle_q        <= idle_d;
      seen_q        <= seen_d;
      slots_q       <= slots_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      an_err_q      <= an_err_d;
      dead_q        <= dead_d;
    end
  end

  assign digits       = digits_q;
  assign frame_valid  = frame_valid_q;
  assign seg_err      = seg_err_q;
  assign an_err       = an_err_q;
  assign display_dead = dead_q;

endmodule
